// File: rtl/mp3_stream_ctrl.sv
// mp3_stream_ctrl: VS10xx-class decoder streamer.
// Resets the codec, sends the SCI init sequence, then streams one of N_TRACKS
// tracks from a shared flat ROM over SDI in 32-bit words under DREQ flow
// control. Supports on-the-fly volume writes, pause, optional looping and a
// one-cycle track-done pulse.
//
// Ports:
//   CLK, RST_N            system clock, asynchronous active-low reset
//   track_sel             one-hot track request (lowest set bit wins, 0 = stop)
//   track_base/track_len  packed per-track start address / length in words
//   vol, vol_wr           SCI_VOL value and its one-cycle write strobe
//   pause                 level; blocks the start of new SDI words
//   rom_addr, rom_data    ROM port, 1-cycle read latency
//   MP3_*                 codec pins (DREQ is synchronised internally)
//   busy, track_done      status; state_dbg exposes the FSM state code
module mp3_stream_ctrl #(
    parameter int N_TRACKS = 4,
    parameter int ADDR_W   = 17,
    parameter int CLK_DIV  = 50,
    parameter int RST_HOLD = 16,
    parameter int LOOP     = 0
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [N_TRACKS-1:0]          track_sel,
    input  logic [N_TRACKS*ADDR_W-1:0]   track_base,
    input  logic [N_TRACKS*ADDR_W-1:0]   track_len,
    input  logic [15:0]                  vol,
    input  logic                         vol_wr,
    input  logic                         pause,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [31:0]                  rom_data,
    output logic                         MP3_RSET,
    output logic                         MP3_CS,
    output logic                         MP3_DCS,
    output logic                         MP3_SCLK,
    output logic                         MP3_MOSI,
    input  logic                         MP3_DREQ,
    output logic                         busy,
    output logic                         track_done,
    output logic [3:0]                   state_dbg
);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int K_W    = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1;

    localparam logic [3:0] S_HOLD   = 4'd0;
    localparam logic [3:0] S_WAKE   = 4'd1;
    localparam logic [3:0] S_INIT   = 4'd2;
    localparam logic [3:0] S_IDLE   = 4'd3;
    localparam logic [3:0] S_FETCH  = 4'd4;
    localparam logic [3:0] S_WAITQ  = 4'd5;
    localparam logic [3:0] S_SEND   = 4'd6;
    localparam logic [3:0] S_VOLCMD = 4'd7;
    localparam logic [3:0] S_END    = 4'd8;

    logic [3:0]          state_q, state_d, ret_q, ret_d;
    logic [K_W-1:0]      k_q, k_d, pick;
    logic [N_TRACKS-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0]   pos_q, pos_d, addr_q, addr_d;
    logic [31:0]         word_q, word_d, init_word;
    logic                fcnt_q, fcnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          init_q, init_d;
    logic                armed_q, armed_d;
    logic [15:0]         vol_q;
    logic                pend_q, pend_clr;
    logic [DIV_W-1:0]    div_q;
    logic                tick;
    logic                dreq_s1_q, dreq_s2_q;
    logic [ADDR_W-1:0]   base_a [N_TRACKS];
    logic [ADDR_W-1:0]   len_a  [N_TRACKS];

    // Serial engine. Handshake: the FSM may raise sh_start (with sh_data and
    // sh_sdi) only while sh_on_q is low; the engine takes the word on that
    // cycle and raises sh_done for exactly one cycle, the same cycle its chip
    // select returns high. No back-pressure beyond sh_on_q.
    logic                sh_start, sh_sdi, sh_done;
    logic [31:0]         sh_data;
    logic                sh_on_q, sh_sdi_q;
    logic [6:0]          sh_cnt_q;
    logic [31:0]         sr_q;
    logic                cs_q, dcs_q, sclk_q, mosi_q;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));
    // Tick 0 drops the chip select, ticks 1..64 are SCLK edges, tick 65 releases it.
    assign sh_done = sh_on_q && tick && (sh_cnt_q == 7'd65);

    always_comb begin
        for (int i = 0; i < N_TRACKS; i++) begin
            base_a[i] = track_base[i*ADDR_W +: ADDR_W];
            len_a[i]  = track_len[i*ADDR_W +: ADDR_W];
        end
    end

    // Lowest set bit wins: scan downwards so the last hit is the lowest index.
    always_comb begin
        pick = '0;
        for (int i = N_TRACKS - 1; i >= 0; i--) begin
            if (track_sel[i]) pick = K_W'(i);
        end
    end

    always_comb begin
        case (init_q)
            2'd0:    init_word = 32'h0200_0804;
            2'd1:    init_word = 32'h0203_9800;
            2'd2:    init_word = 32'h0202_0055;
            default: init_word = {16'h020B, vol_q};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        k_d      = k_q;
        sel_d    = sel_q;
        pos_d    = pos_q;
        addr_d   = addr_q;
        word_d   = word_q;
        fcnt_d   = fcnt_q;
        hold_d   = hold_q;
        init_d   = init_q;
        armed_d  = armed_q;
        sh_start = 1'b0;
        sh_sdi   = 1'b0;
        sh_data  = word_q;
        pend_clr = 1'b0;
        // An all-zero request re-arms playback after a non-looping track end.
        if (track_sel == '0) armed_d = 1'b1;
        case (state_q)
            S_HOLD: begin
                if (tick) begin
                    if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                        hold_d  = '0;
                        state_d = S_WAKE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            S_WAKE: if (dreq_s2_q) state_d = S_INIT;
            S_INIT: begin
                if (sh_done) begin
                    init_d = init_q + 2'd1;
                    if (init_q == 2'd3) state_d = S_IDLE;
                end else if (!sh_on_q && dreq_s2_q) begin
                    sh_start = 1'b1;
                    sh_data  = init_word;
                    // The last init word carries the latest volume already.
                    if (init_q == 2'd3) pend_clr = 1'b1;
                end
            end
            S_IDLE: begin
                if (pend_q) begin
                    ret_d    = S_IDLE;
                    state_d  = S_VOLCMD;
                    sh_start = 1'b1;
                    sh_data  = {16'h020B, vol_q};
                    pend_clr = 1'b1;
                end else if (armed_q && (track_sel != '0)) begin
                    k_d   = pick;
                    sel_d = track_sel;
                    pos_d = '0;
                    if (len_a[pick] == '0) begin
                        state_d = S_END;
                    end else begin
                        addr_d  = base_a[pick];
                        fcnt_d  = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // Address was registered on entry; data is valid one cycle later.
                if (fcnt_q) begin
                    word_d  = rom_data;
                    state_d = S_WAITQ;
                end else begin
                    fcnt_d = 1'b1;
                end
            end
            S_WAITQ: begin
                if (track_sel != sel_q) begin
                    state_d = S_IDLE;
                end else if (pend_q) begin
                    ret_d    = S_WAITQ;
                    state_d  = S_VOLCMD;
                    sh_start = 1'b1;
                    sh_data  = {16'h020B, vol_q};
                    pend_clr = 1'b1;
                end else if (!pause && dreq_s2_q) begin
                    state_d  = S_SEND;
                    sh_start = 1'b1;
                    sh_sdi   = 1'b1;
                end
            end
            S_SEND: begin
                if (sh_done) begin
                    pos_d = pos_q + ADDR_W'(1);
                    if (pos_d == len_a[k_q]) begin
                        state_d = S_END;
                    end else begin
                        addr_d  = base_a[k_q] + pos_d;
                        fcnt_d  = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_VOLCMD: if (sh_done) state_d = ret_q;
            S_END: begin
                if ((LOOP != 0) && (len_a[k_q] != '0)) begin
                    pos_d   = '0;
                    addr_d  = base_a[k_q];
                    fcnt_d  = 1'b0;
                    state_d = S_FETCH;
                end else begin
                    armed_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_HOLD;
            ret_q     <= S_IDLE;
            k_q       <= '0;
            sel_q     <= '0;
            pos_q     <= '0;
            addr_q    <= '0;
            word_q    <= '0;
            fcnt_q    <= 1'b0;
            hold_q    <= '0;
            init_q    <= '0;
            armed_q   <= 1'b1;
            vol_q     <= 16'h2020;
            pend_q    <= 1'b0;
            div_q     <= '0;
            dreq_s1_q <= 1'b0;
            dreq_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            k_q       <= k_d;
            sel_q     <= sel_d;
            pos_q     <= pos_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
            fcnt_q    <= fcnt_d;
            hold_q    <= hold_d;
            init_q    <= init_d;
            armed_q   <= armed_d;
            div_q     <= tick ? '0 : div_q + DIV_W'(1);
            dreq_s1_q <= MP3_DREQ;
            dreq_s2_q <= dreq_s1_q;
            if (vol_wr) vol_q <= vol;
            // A new write request wins over a clear in the same cycle.
            if (vol_wr)        pend_q <= 1'b1;
            else if (pend_clr) pend_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_on_q  <= 1'b0;
            sh_sdi_q <= 1'b0;
            sh_cnt_q <= '0;
            sr_q     <= '0;
            cs_q     <= 1'b1;
            dcs_q    <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else if (sh_start) begin
            sh_on_q  <= 1'b1;
            sh_sdi_q <= sh_sdi;
            sh_cnt_q <= '0;
            sr_q     <= sh_data;
        end else if (sh_on_q && tick) begin
            sh_cnt_q <= sh_cnt_q + 7'd1;
            if (sh_cnt_q == 7'd0) begin
                if (sh_sdi_q) dcs_q <= 1'b0;
                else          cs_q  <= 1'b0;
                mosi_q <= sr_q[31];
            end else if (sh_cnt_q == 7'd65) begin
                cs_q    <= 1'b1;
                dcs_q   <= 1'b1;
                mosi_q  <= 1'b0;
                sh_on_q <= 1'b0;
            end else if (sh_cnt_q[0]) begin
                sclk_q <= 1'b1;
            end else begin
                // Falling edge: present the next bit while SCLK is low.
                sclk_q <= 1'b0;
                mosi_q <= sr_q[30];
                sr_q   <= {sr_q[30:0], 1'b0};
            end
        end
    end

    assign rom_addr   = addr_q;
    assign MP3_RSET   = (state_q != S_HOLD);
    assign MP3_CS     = cs_q;
    assign MP3_DCS    = dcs_q;
    assign MP3_SCLK   = sclk_q;
    assign MP3_MOSI   = mosi_q;
    assign busy       = (state_q != S_IDLE);
    assign track_done = (state_q == S_END);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mp3_stream_ctrl.sv
// Directed bench for mp3_stream_ctrl: a main instance (LOOP=0) and a looping
// instance (LOOP=1) share clock, reset and most inputs. A pin monitor rebuilds
// SCI/SDI frames from the codec pins so each test compares reconstructed
// words against hand-computed values.
module tb_mp3_stream_ctrl;
    localparam int CLK_DIV  = 2;
    localparam int RST_HOLD = 4;
    localparam int NT       = 4;
    localparam int AW       = 17;

    logic              clk;
    logic              rst_n;
    logic [NT-1:0]     track_sel, sel_loop;
    logic [NT*AW-1:0]  track_base, track_len, track_len_l;
    logic [15:0]       vol;
    logic              vol_wr, pause, dreq;
    logic [AW-1:0]     rom_addr, rom_addr_l;
    logic [31:0]       rom_data, rom_data_l;
    logic              rset, cs, dcs, sclk, mosi, busy, track_done;
    logic              rset_l, cs_l, dcs_l, sclk_l, mosi_l, busy_l, track_done_l;
    logic [3:0]        state_dbg, state_dbg_l;
    logic [31:0]       rom_mem [0:511];

    int n_vec = 0;
    int n_err = 0;

    // Monitor results: {is_sdi, word}, bit counts, loop-instance word addresses.
    logic [32:0] log_q[$];
    int          bits_q[$];
    logic [AW-1:0] laddr_q[$];
    int          done_cnt  = 0;
    int          ldone_cnt = 0;

    mp3_stream_ctrl #(.N_TRACKS(NT), .ADDR_W(AW), .CLK_DIV(CLK_DIV),
                      .RST_HOLD(RST_HOLD), .LOOP(0)) dut (
        .CLK(clk), .RST_N(rst_n), .track_sel(track_sel), .track_base(track_base),
        .track_len(track_len), .vol(vol), .vol_wr(vol_wr), .pause(pause),
        .rom_addr(rom_addr), .rom_data(rom_data), .MP3_RSET(rset), .MP3_CS(cs),
        .MP3_DCS(dcs), .MP3_SCLK(sclk), .MP3_MOSI(mosi), .MP3_DREQ(dreq),
        .busy(busy), .track_done(track_done), .state_dbg(state_dbg)
    );

    mp3_stream_ctrl #(.N_TRACKS(NT), .ADDR_W(AW), .CLK_DIV(CLK_DIV),
                      .RST_HOLD(RST_HOLD), .LOOP(1)) dut_loop (
        .CLK(clk), .RST_N(rst_n), .track_sel(sel_loop), .track_base(track_base),
        .track_len(track_len_l), .vol(vol), .vol_wr(vol_wr), .pause(pause),
        .rom_addr(rom_addr_l), .rom_data(rom_data_l), .MP3_RSET(rset_l), .MP3_CS(cs_l),
        .MP3_DCS(dcs_l), .MP3_SCLK(sclk_l), .MP3_MOSI(mosi_l), .MP3_DREQ(1'b1),
        .busy(busy_l), .track_done(track_done_l), .state_dbg(state_dbg_l)
    );

    // ---------------- clock / ROM models ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data   <= rom_mem[rom_addr[8:0]];
        rom_data_l <= rom_mem[rom_addr_l[8:0]];
    end

    // ---------------- pin monitor ----------------
    initial begin
        logic [31:0] sh;
        int          nb;
        logic        cs_p, dcs_p, sclk_p, dcsl_p;
        sh = '0; nb = 0; cs_p = 1'b1; dcs_p = 1'b1; sclk_p = 1'b0; dcsl_p = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb = 0; cs_p = 1'b1; dcs_p = 1'b1; sclk_p = 1'b0; dcsl_p = 1'b1;
            end else begin
                if ((!cs && cs_p) || (!dcs && dcs_p)) nb = 0;
                if (sclk && !sclk_p) begin
                    sh = {sh[30:0], mosi};
                    nb++;
                end
                if (cs && !cs_p) begin
                    log_q.push_back({1'b0, sh});
                    bits_q.push_back(nb);
                end
                if (dcs && !dcs_p) begin
                    log_q.push_back({1'b1, sh});
                    bits_q.push_back(nb);
                end
                if (track_done) done_cnt++;
                if (!dcs_l && dcsl_p) laddr_q.push_back(rom_addr_l);
                if (track_done_l) ldone_cnt++;
                cs_p = cs; dcs_p = dcs; sclk_p = sclk; dcsl_p = dcs_l;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int target, input int budget);
        for (int c = 0; c < budget && log_q.size() < target; c++) @(negedge clk);
    endtask

    task automatic wait_dcs(input logic level, input int budget);
        for (int c = 0; c < budget && dcs !== level; c++) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        wait_cycles(3);
        n_vec++;
        if ({rset, cs, dcs, sclk, mosi, busy, track_done} !== 7'b0110010) begin
            n_err++;
            $display("FAIL reset_pins: got %b expected 0110010", {rset, cs, dcs, sclk, mosi, busy, track_done});
        end
        n_vec++;
        if (state_dbg !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        n_vec++;
        if (rom_addr !== '0) begin
            n_err++;
            $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr);
        end
    endtask

    task automatic check_init_frames(input int b, input string tag);
        logic [32:0] exp_w [4];
        exp_w[0] = {1'b0, 32'h0200_0804};
        exp_w[1] = {1'b0, 32'h0203_9800};
        exp_w[2] = {1'b0, 32'h0202_0055};
        exp_w[3] = {1'b0, 32'h020B_2020};
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (log_q[b+i] !== exp_w[i] || bits_q[b+i] != 32) begin
                n_err++;
                $display("FAIL %s_word%0d: got %h/%0d bits expected %h/32 bits",
                         tag, i, log_q[b+i], bits_q[b+i], exp_w[i]);
            end
        end
    endtask

    task automatic test_init;
        int n;
        int b;
        b = log_q.size();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!rset && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_vec++;
        if (n != 2 * RST_HOLD) begin
            n_err++;
            $display("FAIL rset_hold: got %0d CLK expected %0d CLK", n, 2 * RST_HOLD);
        end
        wait_log(b + 3, 2000);
        for (int c = 0; c < 100 && cs !== 1'b0; c++) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || state_dbg !== 4'd2) begin
            n_err++;
            $display("FAIL init_busy: got busy=%b state=%0d expected busy=1 state=2", busy, state_dbg);
        end
        wait_log(b + 4, 1000);
        @(negedge clk);
        n_vec++;
        if (log_q.size() != b + 4) begin
            n_err++;
            $display("FAIL init_count: got %0d frames expected 4", log_q.size() - b);
        end
        check_init_frames(b, "init");
        n_vec++;
        if (busy !== 1'b0 || state_dbg !== 4'd3) begin
            n_err++;
            $display("FAIL init_idle: got busy=%b state=%0d expected busy=0 state=3", busy, state_dbg);
        end
    endtask

    task automatic test_empty_track;
        int b, d0;
        b = log_q.size(); d0 = done_cnt;
        track_sel = 4'b0001;
        wait_cycles(300);
        n_vec++;
        if (done_cnt - d0 != 1 || log_q.size() != b) begin
            n_err++;
            $display("FAIL empty_track: got done=%0d frames=%0d expected done=1 frames=0",
                     done_cnt - d0, log_q.size() - b);
        end
        track_sel = 4'b0000;
        wait_cycles(5);
    endtask

    task automatic test_play;
        int b, d0;
        logic [32:0] exp_w [3];
        exp_w[0] = {1'b1, 32'hA5A5_0001};
        exp_w[1] = {1'b1, 32'hA5A5_0002};
        exp_w[2] = {1'b1, 32'hA5A5_0003};
        b = log_q.size(); d0 = done_cnt;
        track_sel = 4'b0010;
        wait_log(b + 3, 3000);
        wait_cycles(3);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (log_q[b+i] !== exp_w[i] || bits_q[b+i] != 32) begin
                n_err++;
                $display("FAIL play_word%0d: got %h/%0d bits expected %h/32 bits",
                         i, log_q[b+i], bits_q[b+i], exp_w[i]);
            end
        end
        n_vec++;
        if (done_cnt - d0 != 1 || state_dbg !== 4'd3) begin
            n_err++;
            $display("FAIL play_done: got done=%0d state=%0d expected done=1 state=3",
                     done_cnt - d0, state_dbg);
        end
    endtask

    task automatic test_no_restart;
        int b, d0;
        b = log_q.size(); d0 = done_cnt;
        wait_cycles(600);
        n_vec++;
        if (log_q.size() != b || done_cnt != d0 || state_dbg !== 4'd3) begin
            n_err++;
            $display("FAIL no_restart: got frames=%0d done=%0d state=%0d expected 0/0/3",
                     log_q.size() - b, done_cnt - d0, state_dbg);
        end
        track_sel = 4'b0000;
        wait_cycles(5);
    endtask

    task automatic test_dreq_gap;
        int b, bad, n;
        logic [32:0] exp_w [3];
        exp_w[0] = {1'b1, 32'hA5A5_0001};
        exp_w[1] = {1'b1, 32'hA5A5_0002};
        exp_w[2] = {1'b1, 32'hA5A5_0003};
        b = log_q.size();
        track_sel = 4'b0010;
        wait_dcs(1'b0, 1000);
        wait_dcs(1'b1, 1000);
        dreq = 1'b0;
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (dcs !== 1'b1 || sclk !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0 || log_q.size() != b + 1) begin
            n_err++;
            $display("FAIL dreq_gap_idle: got %0d active cycles frames=%0d expected 0 and 1", bad, log_q.size() - b);
        end
        dreq = 1'b1;
        n = 0;
        while (dcs !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n > 2 * CLK_DIV + 3) begin
            n_err++;
            $display("FAIL dreq_resume: got %0d CLK expected <= %0d CLK", n, 2 * CLK_DIV + 3);
        end
        wait_log(b + 3, 2000);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (log_q[b+i] !== exp_w[i]) begin
                n_err++;
                $display("FAIL dreq_word%0d: got %h expected %h", i, log_q[b+i], exp_w[i]);
            end
        end
        track_sel = 4'b0000;
        wait_cycles(5);
    endtask

    task automatic test_vol;
        int b;
        logic [32:0] exp_w [6];
        exp_w[0] = {1'b1, 32'h5A5A_0001};
        exp_w[1] = {1'b1, 32'h5A5A_0002};
        exp_w[2] = {1'b0, 32'h020B_3030};
        exp_w[3] = {1'b1, 32'h5A5A_0003};
        exp_w[4] = {1'b1, 32'h5A5A_0004};
        exp_w[5] = {1'b1, 32'h5A5A_0005};
        b = log_q.size();
        track_sel = 4'b0100;
        wait_log(b + 1, 2000);
        wait_dcs(1'b0, 200);
        wait_cycles(20);
        vol = 16'h3030;
        vol_wr = 1'b1;
        @(negedge clk);
        vol_wr = 1'b0;
        wait_log(b + 6, 6000);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (log_q[b+i] !== exp_w[i] || bits_q[b+i] != 32) begin
                n_err++;
                $display("FAIL vol_seq%0d: got %h/%0d bits expected %h/32 bits",
                         i, log_q[b+i], bits_q[b+i], exp_w[i]);
            end
        end
        wait_cycles(3);
        track_sel = 4'b0000;
        wait_cycles(5);
    endtask

    task automatic test_pause_switch;
        int b, bad;
        logic [32:0] exp_w [5];
        exp_w[0] = {1'b1, 32'hA5A5_0001};
        exp_w[1] = {1'b1, 32'hA5A5_0002};
        exp_w[2] = {1'b1, 32'hA5A5_0001};
        exp_w[3] = {1'b1, 32'hA5A5_0002};
        exp_w[4] = {1'b1, 32'hA5A5_0003};
        b = log_q.size();
        track_sel = 4'b0010;
        wait_dcs(1'b0, 1000);
        wait_dcs(1'b1, 1000);
        pause = 1'b1;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (dcs !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0 || log_q.size() != b + 1) begin
            n_err++;
            $display("FAIL pause_hold: got %0d DCS-low cycles frames=%0d expected 0 and 1", bad, log_q.size() - b);
        end
        pause = 1'b0;
        wait_dcs(1'b0, 100);
        wait_cycles(10);
        track_sel = 4'b1010;
        wait_log(b + 5, 5000);
        wait_cycles(3);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (log_q[b+i] !== exp_w[i] || bits_q[b+i] != 32) begin
                n_err++;
                $display("FAIL switch_word%0d: got %h/%0d bits expected %h/32 bits",
                         i, log_q[b+i], bits_q[b+i], exp_w[i]);
            end
        end
        n_vec++;
        if (state_dbg !== 4'd3) begin
            n_err++;
            $display("FAIL switch_idle: got state %0d expected 3", state_dbg);
        end
        track_sel = 4'b0000;
        wait_cycles(5);
    endtask

    task automatic test_async_reset;
        int b;
        track_sel = 4'b0100;
        wait_dcs(1'b0, 1000);
        wait_cycles(31);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({cs, dcs, rset, sclk, mosi, busy, track_done} !== 7'b1100010) begin
            n_err++;
            $display("FAIL async_reset_pins: got %b expected 1100010", {cs, dcs, rset, sclk, mosi, busy, track_done});
        end
        n_vec++;
        if (state_dbg !== 4'd0 || rom_addr !== '0) begin
            n_err++;
            $display("FAIL async_reset_state: got state=%0d addr=%0d expected 0/0", state_dbg, rom_addr);
        end
        track_sel = 4'b0000;
        @(negedge clk);
        b = log_q.size();
        rst_n = 1'b1;
        wait_log(b + 4, 3000);
        wait_cycles(2);
        n_vec++;
        if (log_q.size() != b + 4 || state_dbg !== 4'd3) begin
            n_err++;
            $display("FAIL replay_count: got %0d frames state=%0d expected 4 frames state=3",
                     log_q.size() - b, state_dbg);
        end
        check_init_frames(b, "replay");
    endtask

    task automatic test_loop;
        int lb, d0;
        logic [AW-1:0] exp_a [5];
        exp_a[0] = 17'd100; exp_a[1] = 17'd101; exp_a[2] = 17'd100;
        exp_a[3] = 17'd101; exp_a[4] = 17'd100;
        lb = laddr_q.size(); d0 = ldone_cnt;
        sel_loop = 4'b0010;
        for (int c = 0; c < 5000 && laddr_q.size() < lb + 5; c++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (laddr_q[lb+i] !== exp_a[i]) begin
                n_err++;
                $display("FAIL loop_addr%0d: got %0d expected %0d", i, laddr_q[lb+i], exp_a[i]);
            end
        end
        n_vec++;
        if (ldone_cnt - d0 != 2) begin
            n_err++;
            $display("FAIL loop_done: got %0d pulses expected 2", ldone_cnt - d0);
        end
        sel_loop = 4'b0000;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom_mem[i] = '0;
        for (int i = 0; i < 3; i++) rom_mem[100+i] = 32'hA5A5_0001 + 32'(i);
        for (int i = 0; i < 5; i++) rom_mem[200+i] = 32'h5A5A_0001 + 32'(i);
        track_base  = {17'd300, 17'd200, 17'd100, 17'd0};
        track_len   = {17'd2,   17'd5,   17'd3,   17'd0};
        track_len_l = {17'd2,   17'd5,   17'd2,   17'd0};
        track_sel = '0; sel_loop = '0;
        vol = 16'h0000; vol_wr = 1'b0; pause = 1'b0; dreq = 1'b1;

        test_reset;
        test_init;
        test_empty_track;
        test_play;
        test_no_restart;
        test_dreq_gap;
        test_vol;
        test_pause_switch;
        test_async_reset;
        test_loop;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mp3_stream_ctrl.md
Name: mp3_stream_ctrl

Overview:
- Parametrised VS10xx-class decoder streamer. Successor to the single-purpose four-song MP3 player.
- Resets the codec and sends the SCI init sequence.
- Streams one of N_TRACKS tracks from a shared flat ROM over SDI, using 32-bit words and DREQ flow control.
- Adds on-the-fly volume writes, pause, optional looping and a track-done pulse.
- Sits between the game/key logic (track select, volume) and the codec pins.

Parameters:
- N_TRACKS, 4: number of selectable tracks.
- ADDR_W, 17: ROM word-address width.
- CLK_DIV, 50: CLK cycles per SCLK half-period (≥1).
- RST_HOLD, 16: SCLK half-periods with MP3_RSET held low.
- LOOP, 0: 1 = restart the track at its end; 0 = stop.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- track_sel  in  N_TRACKS  one-hot track request. All-zero = stop. If several bits are set, the lowest index wins.
- track_base  in  N_TRACKS*ADDR_W  packed start address per track; track i is at bits [i*ADDR_W +: ADDR_W].
- track_len  in  N_TRACKS*ADDR_W  packed length per track, in words. A length of 0 means the track is empty.
- vol  in  16  SCI_VOL value (left byte, right byte).
- vol_wr  in  1  one-CLK pulse requesting a volume write.
- pause  in  1  level; while high, no new SDI word starts.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  32  ROM data, 1-CLK read latency.
- MP3_RSET, MP3_CS, MP3_DCS, MP3_SCLK, MP3_MOSI  out  1  codec pins.
- MP3_DREQ  in  1  codec data request. Synchronise through 2 flops internally.
- busy  out  1  high in every state except IDLE.
- track_done  out  1  one-CLK pulse when a track reaches its end.
- state_dbg  out  4  current state code.

Behaviour:
- Reset values (RST_N low):
  - MP3_RSET=0, MP3_CS=1, MP3_DCS=1, MP3_SCLK=0, MP3_MOSI=0.
  - rom_addr=0, busy=1, track_done=0.
  - state=HOLD; volume register=0x2020; no volume write pending.
- Bit timing:
  - A tick fires every CLK_DIV CLK cycles; SCLK toggles only on ticks.
  - MOSI changes only while SCLK is low. The codec samples MOSI on the SCLK rising edge.
  - Every transfer is 32 bits, MSB first: 64 ticks with the chip select low.
  - CS/DCS falls at least one tick before the first rising edge and rises one tick after the last falling edge.
- States (state_dbg code):
  - HOLD(0): MP3_RSET=0 for RST_HOLD ticks → WAKE.
  - WAKE(1): MP3_RSET=1; wait until synced DREQ=1 → INIT.
  - INIT(2): send 4 SCI words in this order: 0x02000804, 0x02039800, 0x02020055, 0x020B_vvvv (vvvv = volume register). Wait for DREQ=1 before each word. After the 4th word → IDLE.
  - IDLE(3): busy=0. A nonzero, newly presented track_sel latches the winning index k, sets pos=0 → FETCH. A pending volume write is handled first → VOLCMD.
  - FETCH(4): rom_addr = base[k] + pos, using ADDR_W wrap-around arithmetic. Capture rom_data into the shift register 2 CLK later → WAITQ.
  - WAITQ(5): checks run in priority order:
    1. track_sel ≠ latched selection → IDLE.
    2. Volume write pending → VOLCMD.
    3. pause=1 → stay.
    4. DREQ=1 → SEND.
  - SEND(6): transmit 32 bits with DCS low. DREQ is not checked mid-word. After the last bit: DCS=1, pos+1. If pos+1 == len[k] → END, otherwise → FETCH.
  - VOLCMD(7): send SCI word 0x020B_vvvv, clear the pending flag, return to the state it came from.
  - END(8): pulse track_done. LOOP=1 → pos=0, FETCH. LOOP=0 → IDLE, and do not restart until track_sel has been all-zero at least once.
- Selection latching:
  - track_sel is re-evaluated only at word boundaries. A change mid-word never truncates a word.
  - len[k]=0: go straight to END with no SDI traffic.
- Volume:
  - vol_wr copies vol into the volume register and sets pending; a later vol_wr overwrites the value.
  - In INIT the pending flag is ignored; the 4th word already uses the latest value, so the flag is cleared there.
- Asynchronous reset mid-transfer: all outputs go to their reset values immediately. The sequence restarts from HOLD.

Test Plan:
- CLK_DIV=2, RST_HOLD=4, DREQ tied high, release RST_N:
  - RSET low for 8 CLK.
  - Four CS-low frames carrying 0x02000804, 0x02039800, 0x02020055, 0x020B2020 in order.
  - Each frame is exactly 32 rising SCLK edges; busy falls on entering IDLE.
- track_sel=0010, base[1]=100, len[1]=3, ROM[100..102]=A5A5_0001/…0002/…0003, LOOP=0:
  - Three DCS frames with matching MOSI bits.
  - track_done pulses once; then IDLE.
  - No restart while track_sel stays 0010.
- Drop DREQ low after word 1 for 500 CLK:
  - DCS stays high and SCLK stays idle during the gap.
  - Word 2 starts within 2·CLK_DIV+3 CLK after DREQ rises.
- vol=0x3030 with vol_wr pulsed during word 2 of a 5-word track:
  - Word 2 completes intact.
  - A CS frame 0x020B3030 follows.
  - Words 3–5 continue from the correct pos.
- pause=1 for 1000 CLK mid-track; track_sel changed 0010→1010 mid-word:
  - No words are sent while paused.
  - On the selection change, the current word finishes and the block goes to IDLE.
  - It then starts track 1 (lowest set bit) from base[1], pos=0.
- RST_N asserted mid-SEND:
  - Within the same CLK: CS=DCS=1, RSET=0, SCLK=0.
  - Full init replays after release.
- LOOP=1, len=2: addresses go 100,101,100,101…, with track_done pulsing every 2 words.
